inst_sram_axi_bridge: RTL
=========================

# inst_sram_axi_bridge

- Converts the instruction-side SRAM-like request/response interface from the fetch stage into AXI3 read transactions on the CPU bus.
- Sits directly downstream of the fetch stage's inst_sram port and upstream of the AXI crossbar.
- Accepts up to MAX_OUTSTANDING in-order reads.
- Optionally discards responses to requests made stale by an exception or ERET redirect.

## Interface
Parameters:
- ARID_VAL, 4'd0: constant ID driven on arid; the R channel returns in order for this ID.
- MAX_OUTSTANDING, 2: maximum accepted-but-unreturned requests (1..3).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- inst_sram_req  in  1  request valid from fetch.
- inst_sram_wr  in  1  write flag; must be 0; a request with wr=1 is never accepted.
- inst_sram_size  in  2  log2 bytes (2'b10 = word).
- inst_sram_addr  in  32  byte address.
- inst_sram_addr_ok  out  1  request accepted this cycle.
- inst_sram_data_ok  out  1  read data valid this cycle.
- inst_sram_rdata  out  32  read data.
- fetch_cancel  in  1  one-cycle pulse: all earlier-accepted requests become stale.
- arid  out  4  read ID.
- araddr  out  32  read address.
- arlen  out  8  fixed 0.
- arsize  out  3  burst size.
- arburst  out  2  fixed 2'b01.
- arlock  out  2  fixed 0.
- arcache  out  4  fixed 0.
- arprot  out  3  fixed 0.
- arvalid  out  1  AR valid.
- arready  in  1  AR ready.
- rid  in  4  read ID (not checked).
- rdata  in  32  read data.
- rresp  in  2  read response (ignored).
- rlast  in  1  last beat (always 1, since arlen=0).
- rvalid  in  1  R valid.
- rready  out  1  R ready.

## Operation
- AR state machine with two states:
  - AR_IDLE: `inst_sram_addr_ok = inst_sram_req & ~inst_sram_wr & (outstanding < MAX_OUTSTANDING)`. On addr_ok, latch araddr = {addr[31:2], 2'b00} and arsize = {1'b0, size}; go to AR_SEND.
  - AR_SEND: arvalid = 1, and araddr/arsize hold stable. On arready, go to AR_IDLE. addr_ok = 0 in AR_SEND, so there is at most one pending AR.
- Outstanding counter, 2 bits:
  - +1 on addr_ok.
  - −1 on an R handshake (rvalid & rready).
  - Both in the same cycle: net 0.
  - It never exceeds MAX_OUTSTANDING and never underflows; an R beat with outstanding==0 is a protocol error and is ignored.
- R path:
  - rready is constant 1 after reset.
  - inst_sram_rdata = rdata, combinational.
  - `inst_sram_data_ok = rvalid & (discard_cnt == 0) & ~fetch_cancel`.
- Cancel: on fetch_cancel, `discard_cnt <= outstanding − (rvalid ? 1 : 0)`.
  - A beat returning in the cancel cycle is itself suppressed.
  - A request accepted in the cancel cycle (addr_ok with fetch_cancel) is NOT stale: it is the redirect target and returns with data_ok.
  - While discard_cnt > 0, each R beat decrements it and data_ok stays 0.
  - A second cancel while discarding reloads discard_cnt by the same rule.
- Reset (async) values:
  - state = AR_IDLE; arvalid = 0; araddr = 0; arsize = 0.
  - outstanding = 0; discard_cnt = 0.
  - addr_ok/data_ok = 0; rready = 0 while reset is asserted, 1 after.
  - Reset mid-transaction abandons all state; the bus is expected to be reset with the CPU.

## Timing
- Request accept (addr_ok) in cycle N; arvalid first high in cycle N+1.
- Minimum request-to-data: arready in N+1 with rvalid in N+2 gives data_ok in N+2.
- data_ok has zero latency from rvalid (combinational path); addr_ok is combinational from req.
- Back-to-back throughput: one request every 2 cycles (accept, then send).

## Configuration
- INST_BRIDGE_CANCEL_EN defined: fetch_cancel behaves as above.
- INST_BRIDGE_CANCEL_EN undefined:
  - fetch_cancel is ignored and no discard_cnt register exists.
  - data_ok = rvalid.
  - Stale responses are delivered, and fetch must filter them.

## Test plan
- Single read: req=1, addr=0xbfc00000, arready=1 in N+1, rvalid in N+2 with rdata=0x3c1dbfc0 -> addr_ok at N; arvalid/araddr=0xbfc00000/arsize=3'b010 at N+1; data_ok with rdata 0x3c1dbfc0 at N+2.
- Backpressure: arready low 5 cycles -> arvalid and araddr stable for 6 cycles; addr_ok stays 0 until handshake.
- Outstanding limit (MAX=2): two accepts with no R -> third req gets addr_ok=0 until one R beat returns, then accepted.
- Cancel: two outstanding, fetch_cancel pulse plus new req to 0xbfc00380 in the same cycle -> the two old beats give data_ok=0; the third beat gives data_ok=1.
- Cancel concurrent with returning beat: outstanding=2, rvalid & fetch_cancel -> that beat suppressed, discard_cnt=1, next beat suppressed, outstanding=0 after.
- Async reset asserted mid-AR_SEND between edges -> arvalid, addr_ok and data_ok drop immediately; after release, a fresh request completes normally.

Source files
------------

// File: rtl/inst_sram_axi_bridge_if.sv
// Fetch-side SRAM-like port plus AXI3 AR/R channels of the instruction bridge.
// master: bridge view (drives AR, rready, addr_ok/data_ok); slave: fetch + bus view.
// No storage here; flow control lives in the bridge.
interface inst_sram_axi_bridge_if;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        fetch_cancel;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr, fetch_cancel,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr, fetch_cancel,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/inst_sram_axi_bridge.sv
// Instruction SRAM-like to AXI3 read bridge, in-order, up to MAX_OUTSTANDING reads.
// Latency: addr_ok combinational, arvalid next cycle, data_ok combinational from rvalid.
// Backpressure: addr_ok held low while an AR is pending or the read limit is reached;
// rready always 1. INST_BRIDGE_CANCEL_EN enables stale-response discard on fetch_cancel.
module inst_sram_axi_bridge #(
    parameter logic [3:0] ARID_VAL        = 4'd0,
    parameter int          MAX_OUTSTANDING = 2
) (
    input logic                    clk,
    input logic                    reset,
    inst_sram_axi_bridge_if.master bus
);
    localparam logic [1:0] MAX_CNT = 2'(MAX_OUTSTANDING);

    typedef enum logic {AR_IDLE, AR_SEND} ar_state_e;

    ar_state_e   state_q, state_d;
    logic        arvalid_q, arvalid_d;
    logic [31:0] araddr_q, araddr_d;
    logic [2:0]  arsize_q, arsize_d;
    logic [1:0]  outstanding_q, outstanding_d;

    logic addr_ok;
    logic r_beat;
    logic r_counted;
    logic unused_sigs;

    assign addr_ok   = ~reset & (state_q == AR_IDLE) & bus.inst_sram_req & ~bus.inst_sram_wr
                     & (outstanding_q < MAX_CNT);
    assign r_beat    = bus.rvalid & bus.rready;
    // A beat with nothing outstanding is a protocol error and must not underflow the count.
    assign r_counted = r_beat & (outstanding_q != 2'd0);

    always_comb begin
        state_d       = state_q;
        arvalid_d     = arvalid_q;
        araddr_d      = araddr_q;
        arsize_d      = arsize_q;
        outstanding_d = outstanding_q + {1'b0, addr_ok} - {1'b0, r_counted};
        case (state_q)
            AR_IDLE: begin
                if (addr_ok) begin
                    state_d   = AR_SEND;
                    arvalid_d = 1'b1;
                    araddr_d  = {bus.inst_sram_addr[31:2], 2'b00};
                    arsize_d  = {1'b0, bus.inst_sram_size};
                end
            end
            AR_SEND: begin
                if (bus.arready) begin
                    state_d   = AR_IDLE;
                    arvalid_d = 1'b0;
                end
            end
            default: begin
                state_d   = AR_IDLE;
                arvalid_d = 1'b0;
            end
        endcase
    end

`ifdef INST_BRIDGE_CANCEL_EN
    logic [1:0] discard_q, discard_d;

    // Everything already accepted is stale; a beat returning this cycle is one of them.
    always_comb begin
        discard_d = discard_q;
        if (bus.fetch_cancel)
            discard_d = outstanding_q - {1'b0, r_counted};
        else if (r_beat && discard_q != 2'd0)
            discard_d = discard_q - 2'd1;
    end

    assign bus.inst_sram_data_ok = ~reset & bus.rvalid & (discard_q == 2'd0) & ~bus.fetch_cancel;
    assign unused_sigs = ^{bus.rid, bus.rresp, bus.rlast, bus.inst_sram_addr[1:0]};
`else
    assign bus.inst_sram_data_ok = ~reset & bus.rvalid;
    assign unused_sigs = ^{bus.rid, bus.rresp, bus.rlast, bus.inst_sram_addr[1:0], bus.fetch_cancel};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= AR_IDLE;
            arvalid_q     <= 1'b0;
            araddr_q      <= 32'd0;
            arsize_q      <= 3'd0;
            outstanding_q <= 2'd0;
`ifdef INST_BRIDGE_CANCEL_EN
            discard_q     <= 2'd0;
`endif
        end else begin
            state_q       <= state_d;
            arvalid_q     <= arvalid_d;
            araddr_q      <= araddr_d;
            arsize_q      <= arsize_d;
            outstanding_q <= outstanding_d;
`ifdef INST_BRIDGE_CANCEL_EN
            discard_q     <= discard_d;
`endif
        end
    end

    assign bus.inst_sram_addr_ok = addr_ok;
    assign bus.inst_sram_rdata   = bus.rdata;
    assign bus.rready            = ~reset;

    assign bus.arid    = ARID_VAL;
    assign bus.araddr  = araddr_q;
    assign bus.arlen   = 8'd0;
    assign bus.arsize  = arsize_q;
    assign bus.arburst = 2'b01;
    assign bus.arlock  = 2'b00;
    assign bus.arcache = 4'd0;
    assign bus.arprot  = 3'd0;
    assign bus.arvalid = arvalid_q;
endmodule
